// File: rtl/axis_trace_arbiter_if.sv
// Bundle of trace producer streams, FIFO write-side stream and arbiter status.
// Ports:
//   s_tdata/s_tvalid/s_tlast/s_tready : C_NUM_PORTS producer streams (packed per port)
//   m_tdata/m_tvalid/m_tlast/m_tready : stream toward the trace FIFO input
//   m_tid                             : source port index of the current beat
//   grant, pkt_done                   : one-hot grant and end-of-packet pulse
// Modports: slave = arbiter view, master = producer/FIFO environment view.
interface axis_trace_arbiter_if #(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_PORTS  = 4,
    parameter int unsigned C_ID_WIDTH   = 3
);
    logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_tdata;
    logic [C_NUM_PORTS-1:0]              s_tvalid;
    logic [C_NUM_PORTS-1:0]              s_tlast;
    logic [C_NUM_PORTS-1:0]              s_tready;
    logic [C_DATA_WIDTH-1:0]             m_tdata;
    logic                                m_tlast;
    logic                                m_tvalid;
    logic                                m_tready;
    logic [C_ID_WIDTH-1:0]               m_tid;
    logic [C_NUM_PORTS-1:0]              grant;
    logic                                pkt_done;

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, m_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid, m_tid, grant, pkt_done
    );

    modport master (
        output s_tdata, s_tvalid, s_tlast, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, m_tid, grant, pkt_done
    );
endinterface

// File: rtl/axis_trace_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream trace FIFO write port
// between C_NUM_PORTS producers. A granted port owns the output until its tlast
// beat is accepted; every output beat carries the source index on m_tid.
// Ports:
//   clk   : FIFO write clock
//   reset : synchronous, active-high
//   bus   : axis_trace_arbiter_if.slave (producer streams in, FIFO stream out,
//           grant / pkt_done status)
module axis_trace_arbiter #(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_PORTS  = 4,
    parameter int unsigned C_ID_WIDTH   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    axis_trace_arbiter_if.slave   bus
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                  state_q, state_d;
    logic [C_ID_WIDTH-1:0]   gnt_idx_q, gnt_idx_d;
    logic [C_ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                    found;

    logic [C_NUM_PORTS-1:0]  s_tready_c;
    logic [C_DATA_WIDTH-1:0] m_tdata_c;
    logic                    m_tlast_c;
    logic                    m_tvalid_c;
    logic [C_ID_WIDTH-1:0]   m_tid_c;
    logic [C_NUM_PORTS-1:0]  grant_c;
    logic                    pkt_done_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    // Arbitration, grant hand-back and combinational pass-through datapath
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        found      = 1'b0;
        s_tready_c = '0;
        m_tdata_c  = '0;
        m_tlast_c  = 1'b0;
        m_tvalid_c = 1'b0;
        m_tid_c    = '0;
        grant_c    = '0;
        pkt_done_c = 1'b0;

        case (state_q)
            IDLE: begin
                // Rotating search: ports at or above rr_ptr first, then the wrap-around part.
                for (int unsigned j = 0; j < C_NUM_PORTS; j++) begin
                    if (!found && bus.s_tvalid[j] && (C_ID_WIDTH'(j) >= rr_ptr_q)) begin
                        found     = 1'b1;
                        gnt_idx_d = C_ID_WIDTH'(j);
                    end
                end
                for (int unsigned j = 0; j < C_NUM_PORTS; j++) begin
                    if (!found && bus.s_tvalid[j] && (C_ID_WIDTH'(j) < rr_ptr_q)) begin
                        found     = 1'b1;
                        gnt_idx_d = C_ID_WIDTH'(j);
                    end
                end
                if (found) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
                    if (gnt_idx_q == C_ID_WIDTH'(i)) begin
                        m_tdata_c     = bus.s_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                        m_tlast_c     = bus.s_tlast[i];
                        m_tvalid_c    = bus.s_tvalid[i];
                        s_tready_c[i] = bus.m_tready;
                        grant_c[i]    = 1'b1;
                    end
                end
                m_tid_c = gnt_idx_q;
                // Release only on an accepted tlast beat; stalls hold the grant.
                if (m_tvalid_c && bus.m_tready && m_tlast_c) begin
                    pkt_done_c = 1'b1;
                    state_d    = IDLE;
                    if (gnt_idx_q == C_ID_WIDTH'(C_NUM_PORTS - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_idx_q + C_ID_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.s_tready = s_tready_c;
    assign bus.m_tdata  = m_tdata_c;
    assign bus.m_tlast  = m_tlast_c;
    assign bus.m_tvalid = m_tvalid_c;
    assign bus.m_tid    = m_tid_c;
    assign bus.grant    = grant_c;
    assign bus.pkt_done = pkt_done_c;

endmodule

// File: tb/tb_axis_trace_arbiter.sv
// Bench for axis_trace_arbiter: per-port source queues drive the producer
// streams, expected output beats go into a scoreboard queue, and a monitor
// pops and compares on every accepted output beat.
module tb_axis_trace_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NP = 4;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [3:0]    gap;
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] tid;
        logic          last;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    beat_t src_q[NP][$];
    exp_t  exp_q[$];
    logic  rdy_q[$];
    int    acc_cyc[$];
    int    rise_cyc[NP];
    bit    flush[NP];
    int    stall_cyc = 0;

    axis_trace_arbiter_if #(.C_DATA_WIDTH(DW), .C_NUM_PORTS(NP), .C_ID_WIDTH(IW)) bus ();

    axis_trace_arbiter #(.C_DATA_WIDTH(DW), .C_NUM_PORTS(NP), .C_ID_WIDTH(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic add_src(input int p, input logic [DW-1:0] d, input logic l, input int gap);
        beat_t b;
        b.gap  = 4'(gap);
        b.last = l;
        b.data = d;
        src_q[p].push_back(b);
    endtask

    task automatic add_exp(input int p, input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.tid  = IW'(p);
        e.last = l;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Bounded wait until every expected beat has been seen.
    task automatic wait_sb(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Source driver: capture handshakes mid-cycle, advance queues after the edge.
    initial begin : driver
        bit                  hs[NP];
        bit                  loaded[NP];
        int                  gap_cnt[NP];
        logic [NP-1:0]       tv, tl, prev_tv;
        logic [NP*DW-1:0]    td;
        prev_tv      = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b1;
        for (int i = 0; i < NP; i++) begin
            loaded[i]  = 0;
            gap_cnt[i] = 0;
            flush[i]   = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NP; i++) hs[i] = bus.s_tvalid[i] & bus.s_tready[i];
            @(posedge clk);
            #1;
            tv = '0;
            tl = '0;
            td = '0;
            for (int i = 0; i < NP; i++) begin
                if (hs[i]) begin
                    void'(src_q[i].pop_front());
                    loaded[i] = 0;
                end
                if (flush[i]) begin
                    src_q[i].delete();
                    loaded[i] = 0;
                    flush[i]  = 0;
                end
                if (!loaded[i] && src_q[i].size() > 0) begin
                    loaded[i]  = 1;
                    gap_cnt[i] = int'(src_q[i][0].gap);
                end
                if (loaded[i] && gap_cnt[i] == 0) begin
                    tv[i]            = 1'b1;
                    tl[i]            = src_q[i][0].last;
                    td[i*DW +: DW]   = src_q[i][0].data;
                end else if (loaded[i]) begin
                    gap_cnt[i]--;
                end
                if (tv[i] && !prev_tv[i]) rise_cyc[i] = cyc;
            end
            prev_tv      = tv;
            bus.s_tvalid = tv;
            bus.s_tlast  = tl;
            bus.s_tdata  = td;
            bus.m_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    // Monitor: scoreboard on accepted beats plus per-cycle handshake invariants.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            chk("s_tready_vs_grant", 64'(bus.s_tready), 64'(bus.grant & {NP{bus.m_tready}}));
            chk("grant_onehot0", 64'($onehot0(bus.grant)), 64'd1);
            chk("pkt_done_timing", 64'(bus.pkt_done),
                64'(bus.m_tvalid & bus.m_tready & bus.m_tlast));
            if (bus.m_tvalid) chk("tid_vs_grant", 64'(bus.grant), 64'(4'b0001 << bus.m_tid));
            if (bus.grant == 4'b0010 && !bus.s_tvalid[1] && bus.s_tvalid[3]) stall_cyc++;
            if (bus.m_tvalid && bus.m_tready) begin
                acc_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(bus.m_tdata), 64'hDEAD_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_tid", 64'(bus.m_tid), 64'(e.tid));
                    chk("beat_data", 64'(bus.m_tdata), 64'(e.data));
                    chk("beat_last", 64'(bus.m_tlast), 64'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(bus.s_tready), 64'd0);
        chk("rst_m_tdata", 64'(bus.m_tdata), 64'd0);
        chk("rst_m_tid", 64'(bus.m_tid), 64'd0);
        chk("rst_m_tlast", 64'(bus.m_tlast), 64'd0);
        chk("rst_pkt_done", 64'(bus.pkt_done), 64'd0);

        // All ports valid, 2-beat packets; port 0 has a second packet: order 0,1,2,3,0
        acc_cyc.delete();
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 2; b++) add_src(p, 32'h100 * p + b, b == 1, 0);
        for (int b = 0; b < 2; b++) add_src(0, 32'h110 + b, b == 1, 0);
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 2; b++) add_exp(p, 32'h100 * p + b, b == 1);
        for (int b = 0; b < 2; b++) add_exp(0, 32'h110 + b, b == 1);
        wait_sb("rr4", 100);
        chk("rr4_beats", 64'(acc_cyc.size()), 64'd10);
        if (acc_cyc.size() == 10) chk("rr4_round_cycles", 64'(acc_cyc[8] - acc_cyc[0]), 64'd12);
        step();

        // Single port 2, 3 beats
        acc_cyc.delete();
        add_src(2, 32'hA0, 1'b0, 0);
        add_src(2, 32'hA1, 1'b0, 0);
        add_src(2, 32'hA2, 1'b1, 0);
        add_exp(2, 32'hA0, 1'b0);
        add_exp(2, 32'hA1, 1'b0);
        add_exp(2, 32'hA2, 1'b1);
        wait_sb("p2", 50);
        chk("p2_beats", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            chk("p2_latency", 64'(acc_cyc[0] - rise_cyc[2]), 64'd1);
            chk("p2_back_to_back", 64'(acc_cyc[2] - acc_cyc[0]), 64'd2);
        end
        step();

        // Port 1 stalls 5 cycles mid-packet while port 3 waits
        stall_cyc = 0;
        add_src(1, 32'hB0, 1'b0, 0);
        add_src(1, 32'hB1, 1'b0, 0);
        add_src(1, 32'hB2, 1'b0, 5);
        add_src(1, 32'hB3, 1'b1, 0);
        for (int b = 0; b < 4; b++) add_exp(1, 32'hB0 + b, b == 3);
        n = 0;
        while (bus.grant != 4'b0010 && n < 20) begin
            step();
            n++;
        end
        chk("stall_p1_granted", 64'(bus.grant), 64'b0010);
        add_src(3, 32'hC0, 1'b0, 0);
        add_src(3, 32'hC1, 1'b1, 0);
        add_exp(3, 32'hC0, 1'b0);
        add_exp(3, 32'hC1, 1'b1);
        wait_sb("stall", 60);
        chk("stall_cycles_held", 64'(stall_cyc), 64'd5);
        step();

        // m_tready 1,0,0,1 during a 4-beat packet on port 0
        acc_cyc.delete();
        for (int b = 0; b < 4; b++) add_src(0, 32'hD0 + b, b == 3, 0);
        for (int b = 0; b < 4; b++) add_exp(0, 32'hD0 + b, b == 3);
        n = 0;
        while (bus.grant == 4'b0000 && n < 20) begin
            step();
            n++;
        end
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b0);
        wait_sb("bp", 50);
        chk("bp_beats", 64'(acc_cyc.size()), 64'd4);
        if (acc_cyc.size() == 4) chk("bp_span", 64'(acc_cyc[3] - acc_cyc[0]), 64'd5);
        step();

        // Reset mid-packet on port 0, then ports 1 and 2 request
        for (int b = 0; b < 4; b++) add_src(0, 32'hE0 + b, b == 3, (b == 2) ? 10 : 0);
        add_exp(0, 32'hE0, 1'b0);
        add_exp(0, 32'hE1, 1'b0);
        wait_sb("prerst", 30);
        reset    = 1'b1;
        flush[0] = 1;
        step();
        reset = 1'b0;
        chk("midrst_grant", 64'(bus.grant), 64'd0);
        chk("midrst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
        chk("midrst_s_tready", 64'(bus.s_tready), 64'd0);
        add_src(1, 32'hF1, 1'b1, 0);
        add_src(2, 32'hF2, 1'b1, 0);
        add_exp(1, 32'hF1, 1'b1);
        add_exp(2, 32'hF2, 1'b1);
        wait_sb("postrst", 30);
        step();

        // rr_ptr=3: single beats on ports 3 and 0, then 0,1,2 to probe rr_ptr=1
        add_src(3, 32'h33, 1'b1, 0);
        add_src(0, 32'h30, 1'b1, 0);
        add_exp(3, 32'h33, 1'b1);
        add_exp(0, 32'h30, 1'b1);
        wait_sb("wrap", 30);
        step();
        add_src(0, 32'h40, 1'b1, 0);
        add_src(1, 32'h41, 1'b1, 0);
        add_src(2, 32'h42, 1'b1, 0);
        add_exp(1, 32'h41, 1'b1);
        add_exp(2, 32'h42, 1'b1);
        add_exp(0, 32'h40, 1'b1);
        wait_sb("rrptr1", 30);
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
